inst_fetch_unit: RTL and testbench

//  Instruction fetch stage upstream of the decode/control stage. Holds the PC and issues
//  one-outstanding word reads to instruction memory over a req/ready + rvalid handshake.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_skid_buf.sv | 52 +++++
 rtl/inst_fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding, reset PC default, opcode map shared with control.
// No logic; pure declarations.
// Opcode values must stay in step with the decode/control stage.
package fetch_pkg;

    localparam int OPC_W = 4;

    // Default boot address; top-level parameter may override it.
    localparam int unsigned RESET_PC_DEF = 0;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    // Opcode 0000 asserts no write strobes downstream, so a zeroed output register is harmless.
    localparam logic [OPC_W-1:0] OPC_NOP  = 4'b0000;
    localparam logic [OPC_W-1:0] OPC_J    = 4'b1000;
    localparam logic [OPC_W-1:0] OPC_BRZ  = 4'b1001;
    localparam logic [OPC_W-1:0] OPC_BRN  = 4'b1011;
    localparam logic [OPC_W-1:0] OPC_SVPC = 4'b1111;

    // Opcode field of a 32-bit instruction word.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] inst);
        return inst[31 -: OPC_W];
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {inst,pc} holding register for a fetch response that arrives while decode is stalled.
// Latency: loaded data visible the cycle after load; full flag registered.
// Backpressure: caller loads only when empty and unloads when decode slot frees; clear wins.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int INST_W = 32,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              unload,
    input  logic              clear,
    input  logic [INST_W-1:0] load_inst,
    input  logic [PC_W-1:0]   load_pc,
    output logic [INST_W-1:0] buf_inst,
    output logic [PC_W-1:0]   buf_pc,
    output logic              full
);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } entry_t;

    entry_t entry;

    // Occupancy: clear (redirect) beats load, load beats unload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

    // Payload capture; contents are don't-care while empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (load) begin
            entry <= '{inst: load_inst, pc: load_pc};
        end
    end

    assign buf_inst = entry.inst;
    assign buf_pc   = entry.pc;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC register, one-outstanding imem read FSM, registered {inst,pc,valid} to decode.
// Latency: issue to inst_valid = 1 cycle after rvalid; 1 instruction per 2 cycles with 1-cycle memory.
// Backpressure: stall holds outputs bit-exact; a response landing under stall parks in the skid buffer.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          PC_W     = 8,
    parameter int          INST_W   = 32,
    parameter int unsigned RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              inst_valid
);

    fetch_state_t      state, state_nxt;
    logic [PC_W-1:0]   pc, pc_nxt;
    logic              squash, squash_nxt;

    logic              slot_free;
    logic              flush;
    logic              load_out;
    logic [INST_W-1:0] load_inst;
    logic [PC_W-1:0]   load_pc;

    logic              buf_load, buf_unload, buf_clear;
    logic [INST_W-1:0] buf_inst;
    logic [PC_W-1:0]   buf_pc;
    logic              buf_full;

    // Decode slot can take a new instruction if it is empty or being consumed this edge.
    assign slot_free = ~inst_valid | ~stall;
    assign imem_req  = (state == ST_REQ);
    assign imem_addr = pc;

    // Next-state, PC, squash and output-load decisions; redirect outranks everything except BOOT.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        squash_nxt = squash;
        flush      = 1'b0;
        load_out   = 1'b0;
        load_inst  = imem_rdata;
        load_pc    = pc;
        buf_load   = 1'b0;
        buf_unload = 1'b0;
        buf_clear  = 1'b0;
        case (state)
            ST_BOOT: begin
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_en) begin
                    flush     = 1'b1;
                    buf_clear = 1'b1;
                    pc_nxt    = redirect_pc;
                    // A request accepted this same edge carries the old address: drop its data.
                    if (imem_ready) begin
                        state_nxt  = ST_WAIT;
                        squash_nxt = 1'b1;
                    end
                end else if (imem_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_en) begin
                    flush     = 1'b1;
                    buf_clear = 1'b1;
                    pc_nxt    = redirect_pc;
                    if (imem_rvalid) begin
                        state_nxt  = ST_REQ;
                        squash_nxt = 1'b0;
                    end else begin
                        squash_nxt = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (squash) begin
                        squash_nxt = 1'b0;
                        state_nxt  = ST_REQ;
                    end else if (slot_free) begin
                        load_out  = 1'b1;
                        pc_nxt    = pc + PC_W'(1);
                        state_nxt = ST_REQ;
                    end else begin
                        buf_load  = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_en) begin
                    flush     = 1'b1;
                    buf_clear = 1'b1;
                    pc_nxt    = redirect_pc;
                    state_nxt = ST_REQ;
                end else if (slot_free) begin
                    load_out   = 1'b1;
                    load_inst  = buf_inst;
                    load_pc    = buf_pc;
                    buf_unload = 1'b1;
                    pc_nxt     = pc + PC_W'(1);
                    state_nxt  = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    // FSM state, PC and squash registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_BOOT;
            pc     <= PC_W'(RESET_PC);
            squash <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            squash <= squash_nxt;
        end
    end

    // Decode-facing output register: flush ignores stall; consume without reload only drops valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_out   <= '0;
            pc_out     <= '0;
            inst_valid <= 1'b0;
        end else if (flush) begin
            inst_valid <= 1'b0;
        end else if (load_out) begin
            inst_out   <= load_inst;
            pc_out     <= load_pc;
            inst_valid <= 1'b1;
        end else if (slot_free) begin
            inst_valid <= 1'b0;
        end
    end

    fetch_skid_buf #(
        .INST_W (INST_W),
        .PC_W   (PC_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .unload    (buf_unload),
        .clear     (buf_clear),
        .load_inst (imem_rdata),
        .load_pc   (pc),
        .buf_inst  (buf_inst),
        .buf_pc    (buf_pc),
        .full      (buf_full)
    );

    // Occupancy flag is implied by the HOLD state; kept for observability only.
    logic unused_full;
    assign unused_full = buf_full;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: sequential fetch, stall/skid, redirects, reset PC wrap.
// Memory model responds one (or lat) cycles after each accepted request; mem[k] = k*16'h1111.
// Inputs change 1 time unit after the rising edge; monitors sample on the falling edge.
module tb_inst_fetch_unit;

    localparam int PC_W   = 8;
    localparam int INST_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance, RESET_PC = 0
    logic              rst_n, stall, redirect_en, imem_ready;
    logic [PC_W-1:0]   redirect_pc;
    logic              imem_req, inst_valid;
    logic [PC_W-1:0]   imem_addr, pc_out;
    logic              imem_rvalid = 1'b0;
    logic [INST_W-1:0] imem_rdata  = '0;
    logic [INST_W-1:0] inst_out;

    // Second instance, RESET_PC = 8'hFF
    logic              rst2_n, stall2, redirect_en2, imem_ready2;
    logic [PC_W-1:0]   redirect_pc2;
    logic              imem_req2, inst_valid2;
    logic [PC_W-1:0]   imem_addr2, pc_out2;
    logic              imem_rvalid2 = 1'b0;
    logic [INST_W-1:0] imem_rdata2  = '0;
    logic [INST_W-1:0] inst_out2;

    inst_fetch_unit #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid)
    );

    inst_fetch_unit #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC(8'hFF)) dut2 (
        .clk(clk), .rst_n(rst2_n), .stall(stall2), .redirect_en(redirect_en2),
        .redirect_pc(redirect_pc2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ready(imem_ready2), .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .inst_out(inst_out2), .pc_out(pc_out2), .inst_valid(inst_valid2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [INST_W-1:0] memw(input logic [PC_W-1:0] a);
        return 32'(a) * 32'h1111;
    endfunction

    function automatic logic [39:0] ent(input logic [PC_W-1:0] a);
        return {a, memw(a)};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Recorded traffic: issued addresses and instructions accepted by decode
    logic [PC_W-1:0] iss_q[$];
    logic [39:0]     acc_q[$];
    int              acc_cyc[$];
    logic [PC_W-1:0] iss2_q[$];
    logic [39:0]     acc2_q[$];

    int              lat = 1, pcnt = 0;
    logic [PC_W-1:0] paddr = '0;
    int              lat2 = 1, pcnt2 = 0;
    logic [PC_W-1:0] paddr2 = '0;

    // Memory model and monitor for the main instance
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        if (pcnt > 0) begin
            pcnt--;
            if (pcnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memw(paddr);
            end
        end
        if (imem_req === 1'b1 && imem_ready === 1'b1) begin
            pcnt  = lat;
            paddr = imem_addr;
            iss_q.push_back(imem_addr);
        end
        if (inst_valid === 1'b1 && stall === 1'b0) begin
            acc_q.push_back({pc_out, inst_out});
            acc_cyc.push_back(cyc);
        end
    end

    // Memory model and monitor for the second instance
    always @(negedge clk) begin
        imem_rvalid2 = 1'b0;
        if (pcnt2 > 0) begin
            pcnt2--;
            if (pcnt2 == 0) begin
                imem_rvalid2 = 1'b1;
                imem_rdata2  = memw(paddr2);
            end
        end
        if (imem_req2 === 1'b1 && imem_ready2 === 1'b1) begin
            pcnt2  = lat2;
            paddr2 = imem_addr2;
            iss2_q.push_back(imem_addr2);
        end
        if (inst_valid2 === 1'b1 && stall2 === 1'b0) acc2_q.push_back({pc_out2, inst_out2});
    end

    function automatic logic [63:0] acc_at(input int i);
        return (i < acc_q.size()) ? 64'(acc_q[i]) : '1;
    endfunction
    function automatic logic [63:0] iss_at(input int i);
        return (i < iss_q.size()) ? 64'(iss_q[i]) : '1;
    endfunction
    function automatic logic [63:0] acc2_at(input int i);
        return (i < acc2_q.size()) ? 64'(acc2_q[i]) : '1;
    endfunction
    function automatic logic [63:0] iss2_at(input int i);
        return (i < iss2_q.size()) ? 64'(iss2_q[i]) : '1;
    endfunction

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0; imem_ready = 1'b1;
        rst2_n = 1'b0; stall2 = 1'b0; redirect_en2 = 1'b0; redirect_pc2 = '0; imem_ready2 = 1'b1;
        tick(3);

        // Reset state
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst",  64'(inst_out),   64'd0);
        check("rst_pc_out", 64'(pc_out),    64'd0);
        check("rst_req",   64'(imem_req),   64'd0);

        // 1: sequential fetch from reset
        iss_q.delete(); acc_q.delete(); acc_cyc.delete();
        rst_n = 1'b1;
        tick(1);
        check("t1_req_after_boot", {55'd0, imem_req, imem_addr}, {55'd0, 1'b1, 8'h00});
        tick(7);
        check("t1_iss0", iss_at(0), 64'h00);
        check("t1_iss1", iss_at(1), 64'h01);
        check("t1_iss2", iss_at(2), 64'h02);
        check("t1_acc0", acc_at(0), 64'(ent(8'h00)));
        check("t1_acc1", acc_at(1), 64'(ent(8'h01)));
        check("t1_rate", (acc_cyc.size() > 1) ? 64'(acc_cyc[1] - acc_cyc[0]) : '1, 64'd2);

        // 2: stall for 5 cycles while an instruction is presented
        for (int i = 0; i < 20 && inst_valid !== 1'b1; i++) tick(1);
        check("t2_valid_seen", 64'(inst_valid), 64'd1);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("t2_frozen_%0d", i), {23'd0, inst_valid, pc_out, inst_out},
                  {23'd0, 1'b1, 8'h03, memw(8'h03)});
        end
        check("t2_hold_no_req", 64'(imem_req), 64'd0);
        acc_q.delete();
        stall = 1'b0;
        tick(6);
        check("t2_acc0", acc_at(0), 64'(ent(8'h03)));
        check("t2_acc1", acc_at(1), 64'(ent(8'h04)));
        check("t2_acc2", acc_at(2), 64'(ent(8'h05)));

        // 3: redirect to 8'h40 while waiting on a slow response, with decode stalled
        for (int i = 0; i < 20 && inst_valid !== 1'b1; i++) tick(1);
        check("t3_valid_seen", 64'(inst_valid), 64'd1);
        stall = 1'b1;
        lat   = 3;
        tick(1);
        check("t3_held_in_wait", {62'd0, inst_valid, imem_req}, {62'd0, 1'b1, 1'b0});
        redirect_en = 1'b1; redirect_pc = 8'h40;
        tick(1);
        redirect_en = 1'b0; stall = 1'b0; lat = 1;
        check("t3_flush", 64'(inst_valid), 64'd0);
        iss_q.delete(); acc_q.delete();
        tick(10);
        check("t3_iss0", iss_at(0), 64'h40);
        check("t3_acc0", acc_at(0), 64'(ent(8'h40)));
        check("t3_acc1", acc_at(1), 64'(ent(8'h41)));

        // 4: redirect to 8'h80 in REQ coincident with the handshake
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick(1);
        check("t4_req_seen", 64'(imem_req), 64'd1);
        redirect_en = 1'b1; redirect_pc = 8'h80;
        tick(1);
        redirect_en = 1'b0;
        check("t4_flush", 64'(inst_valid), 64'd0);
        iss_q.delete(); acc_q.delete();
        tick(8);
        check("t4_iss0", iss_at(0), 64'h80);
        check("t4_acc0", acc_at(0), 64'(ent(8'h80)));
        check("t4_acc1", acc_at(1), 64'(ent(8'h81)));

        // 5: RESET_PC = FF wraps to 00; reset during WAIT ignores the late response
        rst2_n = 1'b1;
        tick(8);
        check("t5_iss0", iss2_at(0), 64'hFF);
        check("t5_iss1", iss2_at(1), 64'h00);
        check("t5_acc0", acc2_at(0), 64'(ent(8'hFF)));
        check("t5_acc1", acc2_at(1), 64'(ent(8'h00)));
        for (int i = 0; i < 20 && imem_req2 !== 1'b1; i++) tick(1);
        check("t5_req_seen", 64'(imem_req2), 64'd1);
        lat2 = 3;
        tick(1);
        rst2_n = 1'b0;
        tick(1);
        check("t5_rst_state", {23'd0, inst_valid2, pc_out2, inst_out2, imem_req2}, 64'd0);
        rst2_n = 1'b1; lat2 = 1;
        iss2_q.delete(); acc2_q.delete();
        tick(8);
        check("t5_post_rst_iss0", iss2_at(0), 64'hFF);
        check("t5_post_rst_acc0", acc2_at(0), 64'(ent(8'hFF)));
        check("t5_post_rst_acc1", acc2_at(1), 64'(ent(8'h00)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
